dec_in_capture: RTL and testbench

- Input interface stage directly upstream of the ADPCM decoder core.
- Takes the 64 kHz serial-domain code bus dec_i, qualified by dec_i_clk and dec_i_fs, into the sysclk domain.
- Extracts the rate-dependent 2–5 bit ADPCM code I, right-justified, and hands it to the core over a valid/ready handshake.
- Flags overrun and framing errors, which feed dec_error.

---
 rtl/dec_in_capture_if.sv | 22 ++
 rtl/dec_in_capture.sv | 167 ++++++++++++++++
 tb/tb_dec_in_capture.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_in_capture_if.sv
// Code handshake between the decoder input capture stage and the ADPCM decoder core.
// The capture stage is the master (drives code/valid), the core is the slave (drives ready).
interface dec_in_capture_if;
    logic [4:0] code_o;
    logic [1:0] code_rate;
    logic       code_valid;
    logic       code_ready;

    modport master (
        output code_o,
        output code_rate,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_o,
        input  code_rate,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/dec_in_capture.sv
// Brings the 64 kHz serial code bus into sysclk, extracts the rate-dependent ADPCM code
// and offers it over valid/ready. Frame-length checking is built only with DEC_IN_FRAME_CHECK_EN.
module dec_in_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_LEN   = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              dec_i_clk,
    input  logic              dec_i_fs,
    input  logic [1:5]        dec_i,
    input  logic [1:0]        RATE,
    dec_in_capture_if.master  code_if,
    output logic              overrun_err,
    output logic              frame_err
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state;

    logic [4:0] code_bus;
    logic [SYNC_STAGES-1:0]      clk_sync;
    logic [SYNC_STAGES-1:0]      fs_sync;
    logic [SYNC_STAGES-1:0][4:0] data_sync;

    logic       sync_clk;
    logic       sync_fs;
    logic [4:0] sync_data;

    logic       sync_clk_d;
    logic       clk_rise;
    logic       fs_d;
    logic [4:0] data_d;
    logic       capture;
    logic       first_frame;

    logic [4:0] new_code;
    logic [4:0] code_q;
    logic [1:0] rate_q;
    logic       valid_q;

    // dec_i[1] is the MSB, so it lands in bit 4 of the packed vector
    assign code_bus  = dec_i;
    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_fs   = fs_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            fs_sync   <= '0;
            data_sync <= '0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], dec_i_clk};
            fs_sync   <= {fs_sync[SYNC_STAGES-2:0], dec_i_fs};
            data_sync <= {data_sync[SYNC_STAGES-2:0], code_bus};
        end
    end

    // fs and data get one extra flop so they line up with the registered clk_rise pulse
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_clk_d <= 1'b0;
            clk_rise   <= 1'b0;
            fs_d       <= 1'b0;
            data_d     <= '0;
        end else begin
            sync_clk_d <= sync_clk;
            clk_rise   <= sync_clk & ~sync_clk_d;
            fs_d       <= sync_fs;
            data_d     <= sync_data;
        end
    end

    assign capture = clk_rise & fs_d;

    always_comb begin
        new_code = data_d;
        case (RATE)
            2'd0: new_code = data_d;
            2'd1: new_code = {1'b0, data_d[4:1]};
            2'd2: new_code = {2'b00, data_d[4:2]};
            2'd3: new_code = {3'b000, data_d[4:3]};
            default: new_code = data_d;
        endcase
    end

    // A capture while FULL is only an overrun if the core is not taking the old code this cycle
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            code_q      <= '0;
            rate_q      <= '0;
            valid_q     <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (capture) begin
                        code_q  <= new_code;
                        rate_q  <= RATE;
                        valid_q <= 1'b1;
                        state   <= FULL;
                    end
                end
                FULL: begin
                    if (capture) begin
                        if (code_if.code_ready) begin
                            code_q <= new_code;
                            rate_q <= RATE;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end else if (code_if.code_ready) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

    assign code_if.code_o     = code_q;
    assign code_if.code_rate  = rate_q;
    assign code_if.code_valid = valid_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            first_frame <= 1'b1;
        end else if (capture) begin
            first_frame <= 1'b0;
        end
    end

`ifdef DEC_IN_FRAME_CHECK_EN
    logic [3:0] edge_cnt;

    // The count compared at a capture is the edges seen since the previous fs, before this edge
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            edge_cnt  <= '0;
            frame_err <= 1'b0;
        end else if (capture) begin
            if (!first_frame && (edge_cnt != 4'(FRAME_LEN))) begin
                frame_err <= 1'b1;
            end
            edge_cnt <= 4'd1;
        end else if (clk_rise && (edge_cnt != 4'd15)) begin
            edge_cnt <= edge_cnt + 4'd1;
        end
    end
`else
    logic frame_check_unused;

    assign frame_check_unused = first_frame;
    assign frame_err          = 1'b0;
`endif

endmodule

// File: tb/tb_dec_in_capture.sv
// Directed bench for dec_in_capture: a serial-event model predicts the handshake and error
// outputs every cycle, and literal checks pin the headline scenarios.
module tb_dec_in_capture;

    localparam int FRAME_LEN = 8;
    localparam int PIPE_LAT  = 4;
`ifdef DEC_IN_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic       dec_i_clk = 1'b0;
    logic       dec_i_fs  = 1'b0;
    logic [1:5] dec_i     = '0;
    logic [1:0] rate      = 2'd0;
    logic       overrun_err;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dec_in_capture_if cif ();

    dec_in_capture #(
        .SYNC_STAGES (2),
        .FRAME_LEN   (FRAME_LEN)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .dec_i_clk   (dec_i_clk),
        .dec_i_fs    (dec_i_fs),
        .dec_i       (dec_i),
        .RATE        (rate),
        .code_if     (cif.master),
        .overrun_err (overrun_err),
        .frame_err   (frame_err)
    );

    always #5 sysclk = ~sysclk;

    // Serial rising edges, keyed by the sysclk cycle at which they reach the handshake
    bit         ev_rise [int];
    bit         ev_fs   [int];
    logic [4:0] ev_val  [int];

    bit         m_valid;
    logic [4:0] m_code;
    logic [1:0] m_rate;
    bit         m_over;
    bit         m_ferr;
    bit         m_first;
    int         m_edges;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One buffer slot, sticky errors, and an edge count per frame
    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_code  = '0;
            m_rate  = '0;
            m_over  = 1'b0;
            m_ferr  = 1'b0;
            m_first = 1'b1;
            m_edges = 0;
            ev_rise.delete();
            ev_fs.delete();
            ev_val.delete();
        end else begin
            cyc++;
            if (ev_rise.exists(cyc) && ev_fs[cyc]) begin
                if (FRAME_CHECK && !m_first && m_edges != FRAME_LEN) m_ferr = 1'b1;
                m_edges = 1;
                m_first = 1'b0;
                if (!m_valid || cif.code_ready) begin
                    m_code  = ev_val[cyc] >> rate;
                    m_rate  = rate;
                    m_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end else begin
                if (ev_rise.exists(cyc) && m_edges < 15) m_edges++;
                if (m_valid && cif.code_ready) m_valid = 1'b0;
            end
        end
    end

    always @(negedge sysclk) begin
        if (!reset) begin
            checkOutput("code_valid", {7'd0, cif.code_valid}, {7'd0, m_valid});
            checkOutput("overrun_err", {7'd0, overrun_err}, {7'd0, m_over});
            checkOutput("frame_err", {7'd0, frame_err}, {7'd0, m_ferr});
            if (m_valid) begin
                checkOutput("code_o", {3'd0, cif.code_o}, {3'd0, m_code});
                checkOutput("code_rate", {6'd0, cif.code_rate}, {6'd0, m_rate});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic raiseClk();
        ev_rise[cyc + PIPE_LAT] = 1'b1;
        ev_fs[cyc + PIPE_LAT]   = dec_i_fs;
        ev_val[cyc + PIPE_LAT]  = dec_i;
        dec_i_clk = 1'b1;
    endtask

    // One serial bit: 8 sysclk long, optional ready pulse exactly on the capture cycle
    task automatic applyStimulus(input bit fs, input logic [4:0] val, input bit pulse);
        dec_i_fs = fs;
        dec_i    = val;
        tick(2);
        raiseClk();
        if (pulse) begin
            tick(PIPE_LAT - 1);
            cif.code_ready = 1'b1;
            tick(1);
            cif.code_ready = 1'b0;
        end else begin
            tick(4);
        end
        dec_i_clk = 1'b0;
        tick(2);
    endtask

    task automatic sendFrame(input int nclk, input logic [4:0] val, input bit pulse);
        for (int i = 0; i < nclk; i++) begin
            applyStimulus(i == 0, val, pulse && (i == 0));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int c0;
        cif.code_ready = 1'b1;
        tick(2);
        checkOutput("rst_valid", {7'd0, cif.code_valid}, 8'h00);
        checkOutput("rst_code", {3'd0, cif.code_o}, 8'h00);
        checkOutput("rst_rate", {6'd0, cif.code_rate}, 8'h00);
        checkOutput("rst_overrun", {7'd0, overrun_err}, 8'h00);
        checkOutput("rst_frame", {7'd0, frame_err}, 8'h00);
        reset = 1'b0;
        tick(3);

        $display("[TB] regular frames, RATE 0");
        dec_i_fs = 1'b1;
        dec_i    = 5'b10110;
        tick(2);
        raiseClk();
        c0  = cyc;
        lat = 10;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cif.code_valid) begin
                lat = cyc - c0;
                break;
            end
        end
        checkOutput("latency", 8'(lat), 8'd4);
        checkOutput("code_16", {3'd0, cif.code_o}, 8'h16);
        if (lat < 4) tick(4 - lat);
        dec_i_clk = 1'b0;
        tick(2);
        for (int i = 1; i < FRAME_LEN; i++) applyStimulus(1'b0, 5'b10110, 1'b0);
        sendFrame(FRAME_LEN, 5'b10110, 1'b0);
        sendFrame(FRAME_LEN, 5'b10110, 1'b0);
        checkOutput("reg_overrun", {7'd0, overrun_err}, 8'h00);
        checkOutput("reg_frame", {7'd0, frame_err}, 8'h00);

        $display("[TB] rate changes");
        cif.code_ready = 1'b0;
        rate = 2'd3;
        sendFrame(FRAME_LEN, 5'b11000, 1'b0);
        checkOutput("r3_code", {3'd0, cif.code_o}, 8'h03);
        checkOutput("r3_rate", {6'd0, cif.code_rate}, 8'h03);
        cif.code_ready = 1'b1;
        tick(1);
        checkOutput("r3_drain", {7'd0, cif.code_valid}, 8'h00);
        cif.code_ready = 1'b0;
        rate = 2'd1;
        sendFrame(FRAME_LEN, 5'b10101, 1'b0);
        checkOutput("r1_code", {3'd0, cif.code_o}, 8'h0A);
        checkOutput("r1_rate", {6'd0, cif.code_rate}, 8'h01);
        cif.code_ready = 1'b1;
        tick(1);

        $display("[TB] ready coincident with capture");
        rate = 2'd0;
        cif.code_ready = 1'b0;
        sendFrame(FRAME_LEN, 5'h07, 1'b0);
        checkOutput("hold_code", {3'd0, cif.code_o}, 8'h07);
        sendFrame(FRAME_LEN, 5'h0C, 1'b1);
        checkOutput("swap_code", {3'd0, cif.code_o}, 8'h0C);
        checkOutput("swap_valid", {7'd0, cif.code_valid}, 8'h01);
        checkOutput("swap_overrun", {7'd0, overrun_err}, 8'h00);
        cif.code_ready = 1'b1;
        tick(1);

        $display("[TB] overrun");
        cif.code_ready = 1'b0;
        sendFrame(FRAME_LEN, 5'h05, 1'b0);
        sendFrame(FRAME_LEN, 5'h09, 1'b0);
        checkOutput("ovr_code", {3'd0, cif.code_o}, 8'h05);
        checkOutput("ovr_flag", {7'd0, overrun_err}, 8'h01);
        cif.code_ready = 1'b1;
        tick(1);
        checkOutput("ovr_drain", {7'd0, cif.code_valid}, 8'h00);

        $display("[TB] short frame");
        sendFrame(6, 5'h03, 1'b0);
        sendFrame(FRAME_LEN, 5'h04, 1'b0);
        checkOutput("short_frame", {7'd0, frame_err}, {7'd0, FRAME_CHECK});
        sendFrame(FRAME_LEN, 5'h04, 1'b0);
        checkOutput("short_sticky", {7'd0, frame_err}, {7'd0, FRAME_CHECK});

        $display("[TB] reset while full");
        cif.code_ready = 1'b0;
        applyStimulus(1'b1, 5'h1F, 1'b0);
        tick(4);
        checkOutput("pre_rst_valid", {7'd0, cif.code_valid}, 8'h01);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", {7'd0, cif.code_valid}, 8'h00);
        checkOutput("arst_code", {3'd0, cif.code_o}, 8'h00);
        checkOutput("arst_overrun", {7'd0, overrun_err}, 8'h00);
        checkOutput("arst_frame", {7'd0, frame_err}, 8'h00);
        tick(1);
        reset = 1'b0;
        cif.code_ready = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'h12, 1'b0);
        sendFrame(FRAME_LEN, 5'h12, 1'b0);
        checkOutput("post_rst_frame", {7'd0, frame_err}, 8'h00);
        sendFrame(FRAME_LEN, 5'h12, 1'b0);
        checkOutput("post_rst_frame2", {7'd0, frame_err}, 8'h00);
        tick(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
